// File: rtl/gpu_ingress_fifo_if.sv
// Flit handshake bundle between the GPU endpoint, the ingress buffer and the leaf router input port.
// The buffer uses the slave modport; whoever drives the GPU side and consumes the router side uses master.
interface gpu_ingress_fifo_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 6
);
  logic [DWIDTH-1:0] gpu_in_data;
  logic              gpu_in_valid;
  logic [AWIDTH-1:0] gpu_dest_addr;
  logic              gpu_in_ready;

  logic [DWIDTH-1:0] rtr_out_data;
  logic              rtr_out_valid;
  logic [AWIDTH-1:0] rtr_dest_addr;
  logic              rtr_dest_local;
  logic              rtr_out_ready;

  modport master (
    output gpu_in_data, gpu_in_valid, gpu_dest_addr, rtr_out_ready,
    input  gpu_in_ready, rtr_out_data, rtr_out_valid, rtr_dest_addr, rtr_dest_local
  );

  modport slave (
    input  gpu_in_data, gpu_in_valid, gpu_dest_addr, rtr_out_ready,
    output gpu_in_ready, rtr_out_data, rtr_out_valid, rtr_dest_addr, rtr_dest_local
  );
endinterface

// File: rtl/gpu_ingress_fifo.sv
// First-word-fall-through ingress FIFO from a GPU endpoint to the leaf router input port,
// with occupancy status, a saturating input-stall counter and a local-group flag on the head flit.
module gpu_ingress_fifo #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned AWIDTH     = 6,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [3:0]  GROUP_ID   = 4'b0101,
  parameter int unsigned CWIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  gpu_ingress_fifo_if.slave             bus,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CWIDTH-1:0]             stall_count
);

  localparam int unsigned PWIDTH = $clog2(FIFO_DEPTH);
  localparam int unsigned EWIDTH = AWIDTH + DWIDTH;
  localparam logic [PWIDTH:0] FULL_COUNT = (PWIDTH + 1)'(FIFO_DEPTH);

  logic [EWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PWIDTH-1:0] wr_ptr;
  logic [PWIDTH-1:0] rd_ptr;
  logic [PWIDTH:0]   count;
  logic [EWIDTH-1:0] head;
  logic              push;
  logic              pop;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign fifo_count = count;

  // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign bus.gpu_in_ready  = !fifo_full;
  assign bus.rtr_out_valid = !fifo_empty;

  assign push = bus.gpu_in_valid && !fifo_full;
  assign pop  = !fifo_empty && bus.rtr_out_ready;

  assign head               = fifo_empty ? '0 : mem[rd_ptr];
  assign bus.rtr_out_data   = head[DWIDTH-1:0];
  assign bus.rtr_dest_addr  = head[EWIDTH-1:DWIDTH];
  assign bus.rtr_dest_local = !fifo_empty && (head[EWIDTH-1 -: 4] == GROUP_ID);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // NOTE: storage has no reset; contents are only ever read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {bus.gpu_dest_addr, bus.gpu_in_data};
  end

  // Stall history survives flush; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (bus.gpu_in_valid && fifo_full && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_gpu_ingress_fifo.sv
// Self-checking bench for gpu_ingress_fifo: table-driven fill/drain vectors plus hand sequences,
// with a scoreboard queue checking every flit the router side accepts.
module tb_gpu_ingress_fifo;

  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam logic [3:0] GROUP = 4'b0101;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    fifo_count;
  logic [CW-1:0] stall_count;

  gpu_ingress_fifo_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  gpu_ingress_fifo #(
    .DWIDTH(DW), .AWIDTH(AW), .FIFO_DEPTH(DEPTH), .GROUP_ID(GROUP), .CWIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [AW+DW-1:0] sb [$];

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [5:0]  a;
    logic        rdy;
    logic        fl;
    logic [3:0]  cnt;
    logic        full;
    logic        empty;
    logic [15:0] head;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle from a negedge, score the handshakes that will fire, and return at the next negedge.
  task automatic cycle(input logic v, input logic [15:0] d, input logic [5:0] a,
                       input logic rdy, input logic fl);
    logic [AW+DW-1:0] exp;
    bus.gpu_in_valid  = v;
    bus.gpu_in_data   = d;
    bus.gpu_dest_addr = a;
    bus.rtr_out_ready = rdy;
    flush             = fl;
    #2;
    if (fl) begin
      sb.delete();
    end else begin
      if (bus.rtr_out_valid && rdy) begin
        check("pop_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("pop_data", 32'(bus.rtr_out_data), 32'(exp[DW-1:0]));
          check("pop_dest", 32'(bus.rtr_dest_addr), 32'(exp[AW+DW-1:DW]));
          check("pop_local", 32'(bus.rtr_dest_local), 32'(exp[AW+DW-1 -: 4] == GROUP));
        end
      end
      if (v && bus.gpu_in_ready) sb.push_back({a, d});
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && bus.rtr_out_valid; i++) cycle(1'b0, 16'h0, 6'h0, 1'b1, 1'b0);
    check({name, "_drained"}, 32'(fifo_empty), 32'd1);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] stall_before;

    vecs[0] = '{1'b1, 16'hA001, 6'b010110, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 16'hA001};
    vecs[1] = '{1'b0, 16'h0000, 6'h00,     1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 16'h0000};
    vecs[2] = '{1'b1, 16'h0001, 6'h01,     1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'h0001};
    vecs[3] = '{1'b1, 16'h0002, 6'h02,     1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 16'h0001};
    vecs[4] = '{1'b1, 16'h0003, 6'h03,     1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 16'h0001};
    vecs[5] = '{1'b1, 16'h0004, 6'h04,     1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 16'h0001};
    vecs[6] = '{1'b1, 16'h0005, 6'h05,     1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 16'h0001};
    vecs[7] = '{1'b1, 16'h0006, 6'h06,     1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 16'h0001};
    vecs[8] = '{1'b1, 16'h0007, 6'h07,     1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 16'h0001};
    vecs[9] = '{1'b1, 16'h0008, 6'h08,     1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 16'h0001};

    reset = 1'b0;
    flush = 1'b0;
    bus.gpu_in_valid  = 1'b0;
    bus.gpu_in_data   = '0;
    bus.gpu_dest_addr = '0;
    bus.rtr_out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_in_ready", 32'(bus.gpu_in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.rtr_out_valid), 32'd0);
    check("rst_out_data", 32'(bus.rtr_out_data), 32'd0);
    check("rst_stall", 32'(stall_count), 32'd0);
    @(negedge clk);

    // Single flit, then fill to full with the router stalled.
    foreach (vecs[i]) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].a, vecs[i].rdy, vecs[i].fl);
      check($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_full", i), 32'(fifo_full), 32'(vecs[i].full));
      check($sformatf("v%0d_empty", i), 32'(fifo_empty), 32'(vecs[i].empty));
      check($sformatf("v%0d_in_ready", i), 32'(bus.gpu_in_ready), 32'(!vecs[i].full));
      check($sformatf("v%0d_out_valid", i), 32'(bus.rtr_out_valid), 32'(!vecs[i].empty));
      check($sformatf("v%0d_head", i), 32'(bus.rtr_out_data), 32'(vecs[i].head));
    end

    // GPU keeps offering a 9th flit against a full buffer.
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0009, 6'h09, 1'b0, 1'b0);
    check("stall_5", 32'(stall_count), 32'd5);
    check("stall_count_full", 32'(fifo_count), 32'd8);
    check("stall_in_ready", 32'(bus.gpu_in_ready), 32'd0);
    check("stall_head", 32'(bus.rtr_out_data), 32'h0001);

    // Release the router: first cycle pops without push-through, then the 9th flit enters.
    cycle(1'b1, 16'h0009, 6'h09, 1'b1, 1'b0);
    check("no_push_through", 32'(fifo_count), 32'd7);
    cycle(1'b1, 16'h0009, 6'h09, 1'b1, 1'b0);
    check("push_after_drop", 32'(fifo_count), 32'd7);
    drain("order");

    // Steady push+pop at occupancy 3 across several pointer wraps.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 16'(16'h0100 + i), 6'(i * 3), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 16'(16'h0200 + i), 6'(i * 3), 1'b1, 1'b0);
      check($sformatf("wrap_count_%0d", i), 32'(fifo_count), 32'd3);
    end
    drain("wrap");

    // Flush with a concurrent push and pop offered.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(16'h0300 + i), 6'h15, 1'b0, 1'b0);
    stall_before = stall_count;
    cycle(1'b1, 16'hDEAD, 6'h15, 1'b1, 1'b1);
    check("flush_empty", 32'(fifo_empty), 32'd1);
    check("flush_count", 32'(fifo_count), 32'd0);
    check("flush_in_ready", 32'(bus.gpu_in_ready), 32'd1);
    check("flush_out_valid", 32'(bus.rtr_out_valid), 32'd0);
    check("flush_stall_kept", 32'(stall_count), 32'(stall_before));
    cycle(1'b0, 16'h0, 6'h0, 1'b1, 1'b0);
    check("flush_dropped", 32'(fifo_empty), 32'd1);
    cycle(1'b1, 16'hBEEF, 6'h17, 1'b0, 1'b0);
    drain("post_flush");

    // Asynchronous reset in the middle of a cycle with 5 flits stored.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 16'(16'h0400 + i), 6'h14, 1'b0, 1'b0);
    check("pre_rst_local", 32'(bus.rtr_dest_local), 32'd1);
    bus.gpu_in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    check("arst_out_valid", 32'(bus.rtr_out_valid), 32'd0);
    check("arst_out_data", 32'(bus.rtr_out_data), 32'd0);
    check("arst_dest", 32'(bus.rtr_dest_addr), 32'd0);
    check("arst_local", 32'(bus.rtr_dest_local), 32'd0);
    check("arst_empty", 32'(fifo_empty), 32'd1);
    check("arst_count", 32'(fifo_count), 32'd0);
    check("arst_in_ready", 32'(bus.gpu_in_ready), 32'd1);
    check("arst_stall", 32'(stall_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0, 6'h0, 1'b1, 1'b0);
      check($sformatf("post_rst_idle_%0d", i), 32'(bus.rtr_out_valid), 32'd0);
    end
    cycle(1'b1, 16'h0501, 6'h2A, 1'b0, 1'b0);
    drain("post_rst");

    // Stall counter saturation at all-ones.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 16'(16'h0600 + i), 6'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 16'h06FF, 6'h3F, 1'b0, 1'b0);
    check("stall_saturate", 32'(stall_count), 32'(4'hF));
    drain("saturate");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpu_ingress_fifo.md
Name: gpu_ingress_fifo

Overview:
- Ingress buffer between a GPU endpoint and the leaf router's GPU input port (gpu_in_data / gpu_in_valid / gpu_dest_addr).
- Accepts flits from the GPU with a valid/ready handshake and stores {dest_addr, data} in a first-word-fall-through FIFO.
- Presents flits to the router with valid/ready backpressure.
- Supplies the real full/empty/count status that the router top level currently ties off, plus a saturating stall counter and a local-group flag.

Parameters:
- DWIDTH, 16, flit data width.
- AWIDTH, 6, destination address width; dest[5:2] is the group, dest[1:0] is the leaf.
- FIFO_DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- GROUP_ID, 4'b0101, this group's ID; used for the local flag.
- CWIDTH, 16, stall counter width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO contents; active-high.
- gpu_in_data  in  DWIDTH  flit from the GPU.
- gpu_in_valid  in  1  GPU flit valid.
- gpu_dest_addr  in  AWIDTH  destination of the GPU flit.
- gpu_in_ready  out  1  buffer can accept a flit.
- rtr_out_data  out  DWIDTH  head flit data to the router.
- rtr_out_valid  out  1  head flit valid.
- rtr_dest_addr  out  AWIDTH  head flit destination.
- rtr_dest_local  out  1  rtr_dest_addr[AWIDTH-1:AWIDTH-4] == GROUP_ID.
- rtr_out_ready  in  1  router accepts the head flit.
- fifo_full  out  1  count == FIFO_DEPTH.
- fifo_empty  out  1  count == 0.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- stall_count  out  CWIDTH  number of cycles with gpu_in_valid=1 and gpu_in_ready=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers and count go to 0; stall_count goes to 0.
  - fifo_empty=1, fifo_full=0, gpu_in_ready=1, rtr_out_valid=0.
  - rtr_out_data=0, rtr_dest_addr=0, rtr_dest_local=0.
  - Storage contents are don't-care.
  - Reset asserted mid-transfer discards all stored flits; nothing is replayed.
- Push occurs when gpu_in_valid && gpu_in_ready. Pop occurs when rtr_out_valid && rtr_out_ready.
- gpu_in_ready = !fifo_full, combinational from the registered count. No push-through when full, even if a pop happens in the same cycle.
- rtr_out_valid = !fifo_empty.
- rtr_out_data and rtr_dest_addr are read combinationally from the entry at rd_ptr (FWFT). When empty, both read as 0.
- Latency: a flit pushed in cycle N appears on rtr_out_* in cycle N+1. The minimum GPU-to-router latency is 1 cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal when empty? No — when empty, valid=0, so no pop occurs; the push alone is performed.
- Pointer width is $clog2(FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH with natural overflow.
- Count transitions:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- Handshake stability: while rtr_out_valid=1 and rtr_out_ready=0, rtr_out_data and rtr_dest_addr hold their values. The head entry is never overwritten, because a full FIFO refuses pushes.
- The GPU must hold data and dest stable until its flit is accepted. The buffer samples the inputs only on push.
- stall_count increments by 1 each cycle in which gpu_in_valid=1 and fifo_full=1. It saturates at all-ones. It is cleared only by reset, not by flush.
- flush=1 on a clock edge:
  - Pointers and count go to 0 and the FIFO becomes empty.
  - Any push or pop in that same cycle is ignored; flush takes priority.
  - gpu_in_ready=1 and rtr_out_valid=0 in the next cycle.
- rtr_dest_local is a combinational compare on the head entry. It is 0 when empty.

Test Plan:
- Reset, then push 0xA001 with dest 6'b010110 in cycle 1 and hold rtr_out_ready=1 → rtr_out_valid=1 in cycle 2 with data 0xA001, dest 0x16, rtr_dest_local=1 (0101==GROUP_ID). fifo_count returns 1→0 after the pop.
- Hold rtr_out_ready=0 and push 8 flits 0x0001..0x0008 → fifo_full=1, gpu_in_ready=0, fifo_count=8, head stays 0x0001. Keep gpu_in_valid high for 5 more cycles → stall_count=5.
- From full, assert rtr_out_ready=1 with gpu_in_valid=1 → one pop per cycle. The 9th flit is accepted only after fifo_full drops. Output order is exactly 0x0001..0x0009 with no loss or duplication.
- Concurrent push and pop across pointer wrap (20 flits, count held at 3) → count constant at 3 and order preserved through the wrap at index 7→0.
- With 4 flits stored, pulse flush together with gpu_in_valid=1 → next cycle fifo_empty=1, count=0, the flushed-cycle flit is dropped, stall_count unchanged.
- With 5 flits stored, drop reset asynchronously mid-cycle → outputs go to reset values immediately. After release, rtr_out_valid=0 until a new push.
